// File: rtl/signed_or_unsigned_mul_acc_if.sv
// Product-in / group-result-out bus of the multiply-accumulate stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface signed_or_unsigned_mul_acc_if #(
  parameter int n         = 8,
  parameter int g         = 4,
  parameter int max_terms = 16
);
  localparam int AW = 2 * n + g;
  localparam int CW = $clog2(max_terms + 1);

  logic            up_valid;
  logic            up_ready;
  logic [2*n-1:0]  up_product;
  logic            up_signed;
  logic            up_last;
  logic            down_valid;
  logic            down_ready;
  logic [AW-1:0]   down_sum;
  logic [CW-1:0]   down_count;
  logic            down_signed;
  logic            down_mismatch;

  modport master (
    output up_valid, up_product, up_signed, up_last, down_ready,
    input  up_ready, down_valid, down_sum, down_count, down_signed, down_mismatch
  );

  modport slave (
    input  up_valid, up_product, up_signed, up_last, down_ready,
    output up_ready, down_valid, down_sum, down_count, down_signed, down_mismatch
  );
endinterface

// File: rtl/signed_or_unsigned_mul_acc.sv
// Accumulates groups of signed or unsigned multiplier products into a guard-bit
// widened sum; each group's sum, beat count and mode flags are held until taken.
module signed_or_unsigned_mul_acc #(
  parameter int n         = 8,
  parameter int g         = 4,
  parameter int max_terms = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  signed_or_unsigned_mul_acc_if.slave   bus,
  output logic                          state_dbg_o
);
  localparam int AW = 2 * n + g;
  localparam int CW = $clog2(max_terms + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(max_terms);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q;
  logic [AW-1:0] acc_q, acc_d, ext_w, down_sum_q;
  logic [CW-1:0] count_q, count_d, down_count_q;
  logic          mode_q, mode_d, mismatch_q, mismatch_d;
  logic          down_signed_q, down_mismatch_q, done_w;

  // The first beat of a group defines the mode; later beats are extended with it.
  always_comb begin
    mode_d     = (count_q == '0) ? bus.up_signed : mode_q;
    ext_w      = mode_d ? {{g{bus.up_product[2*n-1]}}, bus.up_product}
                        : {{g{1'b0}}, bus.up_product};
    acc_d      = acc_q + ext_w;
    count_d    = count_q + 1'b1;
    mismatch_d = mismatch_q | ((count_q != '0) & (bus.up_signed != mode_q));
    done_w     = bus.up_last | (count_d == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ACCUM;
      acc_q           <= '0;
      count_q         <= '0;
      mode_q          <= 1'b0;
      mismatch_q      <= 1'b0;
      down_sum_q      <= '0;
      down_count_q    <= '0;
      down_signed_q   <= 1'b0;
      down_mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.up_valid) begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            mismatch_q <= mismatch_d;
            if (done_w) begin
              down_sum_q      <= acc_d;
              down_count_q    <= count_d;
              down_signed_q   <= mode_d;
              down_mismatch_q <= mismatch_d;
              state_q         <= HOLD;
            end
          end
        end
        HOLD: begin
          // Result taken: start the next group from a clean slate.
          if (bus.down_ready) begin
            acc_q           <= '0;
            count_q         <= '0;
            mode_q          <= 1'b0;
            mismatch_q      <= 1'b0;
            down_sum_q      <= '0;
            down_count_q    <= '0;
            down_signed_q   <= 1'b0;
            down_mismatch_q <= 1'b0;
            state_q         <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.up_ready      = (state_q == ACCUM);
  assign bus.down_valid    = (state_q == HOLD);
  assign bus.down_sum      = down_sum_q;
  assign bus.down_count    = down_count_q;
  assign bus.down_signed   = down_signed_q;
  assign bus.down_mismatch = down_mismatch_q;
  assign state_dbg_o       = state_q;
endmodule

// File: doc/signed_or_unsigned_mul_acc.md
SIGNED_OR_UNSIGNED_MUL_ACC -- requirements
Module: signed_or_unsigned_mul_acc

Interface
REQ-001 The block SHALL have parameter n, default 8, which is the operand width of the upstream multiplier; products are 2n bits.
REQ-002 The block SHALL have parameter g, default 4, which is the number of accumulator guard bits; accumulator width aw = 2n+g.
REQ-003 The block SHALL have parameter max_terms, default 16, which is the maximum number of products per group; legal range 1..2^g.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port up_valid, input, 1 bit: upstream product beat is valid.
REQ-007 The block SHALL have port up_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port up_product, input, 2n bits: the product from the signed/unsigned multiplier.
REQ-009 The block SHALL have port up_signed, input, 1 bit: the product is two's complement (1) or unsigned (0).
REQ-010 The block SHALL have port up_last, input, 1 bit: the beat is the final beat of its group.
REQ-011 The block SHALL have port down_valid, output, 1 bit: a group result is presented.
REQ-012 The block SHALL have port down_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port down_sum, output, aw bits: the accumulated group sum.
REQ-014 The block SHALL have port down_count, output, $clog2(max_terms+1) bits: the number of beats in the group.
REQ-015 The block SHALL have port down_signed, output, 1 bit: the group mode, latched from the first beat.
REQ-016 The block SHALL have port down_mismatch, output, 1 bit: a beat's up_signed differed from the group mode.

Function
REQ-017 The block SHALL define a beat handshake as up_valid && up_ready on a rising edge, and a result handshake as down_valid && down_ready on a rising edge.
REQ-018 The block SHALL implement a two-state FSM: ACCUM (up_ready=1, down_valid=0) and HOLD (up_ready=0, down_valid=1).
REQ-019 In ACCUM, on each beat handshake the block SHALL update acc <= acc + ext(up_product) and count <= count+1; with up_valid=0 it SHALL hold state.
REQ-020 ext() SHALL sign-extend to aw bits when the group mode is signed and zero-extend when it is unsigned.
REQ-021 The group mode SHALL be taken from up_signed on the first beat of a group (count==0) and held for the rest of the group.
REQ-022 On a non-first beat whose up_signed differs from the group mode, the block SHALL set mismatch (sticky per group) and still extend that beat using the group mode.
REQ-023 When a beat handshake has up_last=1, or count+1==max_terms, the block SHALL register the final sum, count and flags into the down_* outputs and go to HOLD on the next edge; latency from last beat to down_valid SHALL be 1 cycle.
REQ-024 In HOLD, down_* outputs SHALL be stable until the result handshake; on the result handshake the block SHALL clear acc, count and mismatch and return to ACCUM on the next edge.
REQ-025 Throughput SHALL be one beat per cycle within a group, plus at least one bubble cycle per group while in HOLD.
REQ-026 The block SHALL never overflow for legal parameters (max_terms <= 2^g); the block SHALL NOT saturate or wrap-detect.
REQ-027 A single-beat group (up_last on the first beat) SHALL produce count=1 and sum=ext(product).

Reset
REQ-028 While rst=1 at an edge, the block SHALL enter ACCUM and clear acc, count, mode and mismatch to 0, with down_valid=0, down_sum=0, down_count=0, down_signed=0, down_mismatch=0 and up_ready=1 from the following cycle.
REQ-029 Reset SHALL abort any partial group or held result; beats presented during reset SHALL be discarded.

Verification (n=8, g=4, max_terms=16, aw=20)
REQ-030 The bench SHALL cover an unsigned group of products 0xFE01 x3 with up_last on the 3rd -> one cycle later down_valid=1, down_sum=0x2FA03, down_count=3, down_signed=0.
REQ-031 The bench SHALL cover a signed group of 0xFF00 then 0x0040 with last -> down_sum=0xFFF40 (-192), down_count=2, down_signed=1.
REQ-032 The bench SHALL cover 16 unsigned beats of 0x0001 without up_last -> down_valid after the 16th beat, down_sum=16, down_count=16; the 17th beat is not accepted (up_ready=0).
REQ-033 The bench SHALL cover a result held with down_ready=0 for 5 cycles -> down_valid=1, outputs unchanged, up_ready=0; when down_ready=1 -> the next cycle up_ready=1 with sum cleared.
REQ-034 The bench SHALL cover a first beat signed 0xFFFF followed by an unsigned beat 0xFFFF with last -> down_mismatch=1, down_sum=0xFFFFE (both sign-extended).
REQ-035 The bench SHALL cover rst asserted after 2 accepted beats -> all outputs at reset values; the next group of a single beat 0x0005 -> down_sum=5, down_count=1.
